// File: rtl/avst_sync_fifo_if.sv
// avst_sync_fifo_if: Avalon-ST valid/ready/data bundle; master drives valid/data, slave drives ready.
interface avst_sync_fifo_if #(parameter int DATA_WIDTH = 32);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/avst_sync_fifo.sv
// avst_sync_fifo: show-ahead synchronous FIFO with Avalon-ST sink/source, readyLatency 0.
// Define AVST_FIFO_FILL_LEVEL_EN to expose the occupancy count on fill_level.
module avst_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input logic clk,
  input logic reset,
  avst_sync_fifo_if.slave  in_if,
  avst_sync_fifo_if.master out_if
`ifdef AVST_FIFO_FILL_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] fill_level
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  // ready is masked by reset so nothing is accepted while the FIFO is being cleared
  assign in_if.ready  = (cnt_q != FULL) && !reset;
  assign out_if.valid = cnt_q != '0;
  assign out_if.data  = mem_q[rp_q];
  assign wr = in_if.valid && in_if.ready;
  assign rd = out_if.valid && out_if.ready;
`ifdef AVST_FIFO_FILL_LEVEL_EN
  assign fill_level = cnt_q;
`endif
  always_comb begin
    wp_d  = wr ? wp_q + 1'b1 : wp_q;
    rp_d  = rd ? rp_q + 1'b1 : rp_q;
    cnt_d = (wr && !rd) ? cnt_q + 1'b1 : (rd && !wr) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= in_if.data;
  end
endmodule

// File: tb/tb_avst_sync_fifo.sv
// tb_avst_sync_fifo: random and directed stimulus against a queue model of the FIFO.
module tb_avst_sync_fifo;
  localparam int DEPTH = 16;
  logic clk = 0;
  logic reset = 1;
  logic armed = 0;
  int vectors = 0;
  int errs = 0;
  logic [31:0] q[$];
  logic [31:0] got[$];
`ifdef AVST_FIFO_FILL_LEVEL_EN
  logic [4:0] fill_level;
`endif
  avst_sync_fifo_if #(.DATA_WIDTH(32)) in_if();
  avst_sync_fifo_if #(.DATA_WIDTH(32)) out_if();
  avst_sync_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_if(in_if), .out_if(out_if)
`ifdef AVST_FIFO_FILL_LEVEL_EN
    , .fill_level(fill_level)
`endif
  );
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    automatic bit push = in_if.valid && q.size() < DEPTH;
    if (reset) begin
      q.delete();
      armed <= 1'b1;
    end else begin
      if (out_if.ready && q.size() > 0) void'(q.pop_front());
      if (push) q.push_back(in_if.data);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 32'(in_if.ready), 32'(!reset && q.size() != DEPTH));
      chk("out_valid", 32'(out_if.valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("out_data", out_if.data, q[0]);
`ifdef AVST_FIFO_FILL_LEVEL_EN
      chk("fill_level", 32'(fill_level), 32'(q.size()));
`endif
      if (out_if.valid && out_if.ready && !reset) got.push_back(out_if.data);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    in_if.valid = v;
    in_if.data = d;
    out_if.ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int bound;
    logic v, rdy;
    in_if.valid = 0;
    in_if.data = 0;
    out_if.ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_if.ready), 32'd0);
    chk("rst_out_valid", 32'(out_if.valid), 32'd0);
    reset = 0;
    #1;
    chk("post_rst_in_ready", 32'(in_if.ready), 32'd1);
    cyc(1, 32'hA5A5_0001, 0);
    cyc(0, 0, 0);
    chk("basic_valid", 32'(out_if.valid), 32'd1);
    chk("basic_data", out_if.data, 32'hA5A5_0001);
    cyc(0, 0, 1);
    chk("basic_empty", 32'(out_if.valid), 32'd0);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 32'(i), 0);
      if (i == 15) chk("full_in_ready", 32'(in_if.ready), 32'd0);
    end
    chk("full_count", 32'(q.size()), 32'd16);
`ifdef AVST_FIFO_FILL_LEVEL_EN
    chk("full_fill_level", 32'(fill_level), 32'd16);
`endif
    got.delete();
    cyc(1, 32'd99, 1);
    chk("full_rd_pops", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("full_rd_head", got[0], 32'd0);
    chk("full_rd_count", 32'(q.size()), 32'd15);
    chk("full_rd_in_ready", 32'(in_if.ready), 32'd1);
    got.delete();
    repeat (15) cyc(0, 0, 1);
    chk("drain_count", 32'(got.size()), 32'd15);
    for (int i = 0; i < got.size(); i++) chk("drain_order", got[i], 32'(i + 1));
    got.delete();
    n = 0;
    bound = 0;
    while (got.size() < 40 && bound < 2000) begin
      v = ($urandom % 2 == 1) && n < 40;
      rdy = in_if.ready;
      cyc(v, 32'(n), 1'($urandom % 2));
      if (v && rdy) n++;
      bound++;
    end
    chk("wrap_count", 32'(got.size()), 32'd40);
    for (int i = 0; i < got.size(); i++) chk("wrap_order", got[i], 32'(i));
    cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 32'(100 + i), 0);
    chk("pre_rst_count", 32'(q.size()), 32'd5);
    reset = 1;
    #1;
    chk("mid_rst_in_ready", 32'(in_if.ready), 32'd0);
    cyc(0, 0, 0);
    chk("mid_rst_out_valid", 32'(out_if.valid), 32'd0);
    chk("mid_rst_in_ready2", 32'(in_if.ready), 32'd0);
    chk("mid_rst_count", 32'(q.size()), 32'd0);
    reset = 0;
    #1;
    chk("after_rst_in_ready", 32'(in_if.ready), 32'd1);
    got.delete();
    cyc(1, 32'h1234, 0);
    cyc(0, 0, 1);
    chk("after_rst_pops", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("after_rst_first", got[0], 32'h1234);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom % 97) == 0;
      cyc(1'($urandom % 4 != 0), $urandom, 1'($urandom % 3 == 0));
    end
    reset = 0;
    cyc(0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
